cpu_mem_host: RTL and testbench

Memory-side responder and program loader for `cpu`. Holds the data RAM and instruction ROM that the CPU accesses over its `sel/write/addr/wdata/rdata` and `pc/inst` ports. Loads both memories from a byte stream with a valid/ready handshake, then releases the CPU through `cpu_setn`. Returns to a halted state when the CPU reports `idle`. This block replaces the behavioural memory model used by the bench with synthesizable RTL.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cpu_mem_sp.sv | 28 ++
 rtl/cpu_mem_host.sv | 119 +++++++++++
 tb/tb_cpu_mem_host.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and default widths for the cpu memory host
package cpu_pkg;

   localparam int IMSB_DEF  = 15;
   localparam int PMSB_DEF  = 7;
   localparam int AMSB_DEF  = 7;
   localparam int DMSB_DEF  = 7;
   localparam int RAM_DEPTH = 2 ** (AMSB_DEF + 1);
   localparam int ROM_DEPTH = 2 ** (PMSB_DEF + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_RAM,
      ST_LOAD_ROM_LO,
      ST_LOAD_ROM_HI,
      ST_PRIME,
      ST_RUN,
      ST_HALT
   } host_state_t;

endpackage

// File: rtl/cpu_mem_sp.sv
// rtl/cpu_mem_sp.sv - one-write/one-read synchronous RAM, read returns old data
module cpu_mem_sp #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Array contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/cpu_mem_host.sv
// rtl/cpu_mem_host.sv - loads cpu RAM/ROM from a byte stream, then serves the cpu
module cpu_mem_host
   import cpu_pkg::*;
#(
   parameter int IMSB = IMSB_DEF,
   parameter int PMSB = PMSB_DEF,
   parameter int AMSB = AMSB_DEF,
   parameter int DMSB = DMSB_DEF
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          load_start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   output logic          ld_ready,
   output logic          busy,
   output logic          halted,
   output logic [15:0]   run_cycles,
   output logic          cpu_setn,
   input  logic          cpu_idle,
   input  logic          cpu_sel,
   input  logic          cpu_write,
   input  logic [AMSB:0] cpu_addr,
   input  logic [DMSB:0] cpu_wdata,
   output logic [DMSB:0] cpu_rdata,
   input  logic [PMSB:0] cpu_pc,
   output logic [IMSB:0] cpu_inst
);

   localparam int PW = (AMSB > PMSB) ? AMSB + 1 : PMSB + 1;

   host_state_t   state, state_nx;
   logic [PW-1:0] ld_ptr;
   logic [7:0]    lo_byte;
   logic          ld_fire, cpu_phase, ram_last, rom_last, can_start;
   logic          ram_we, rom_we;
   logic [AMSB:0] ram_waddr;
   logic [DMSB:0] ram_wdata;

   assign ld_ready  = (state == ST_LOAD_RAM) || (state == ST_LOAD_ROM_LO) ||
                      (state == ST_LOAD_ROM_HI);
   assign ld_fire   = ld_valid && ld_ready;
   assign cpu_phase = (state == ST_PRIME) || (state == ST_RUN);
   assign can_start = (state == ST_IDLE) || (state == ST_HALT);
   assign ram_last  = &ld_ptr[AMSB:0];
   assign rom_last  = &ld_ptr[PMSB:0];
   assign busy      = !can_start;
   assign halted    = (state == ST_HALT);
   assign cpu_setn  = (state == ST_RUN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_HALT: if (load_start) state_nx = ST_LOAD_RAM;
         ST_LOAD_RAM:      if (ld_fire && ram_last) state_nx = ST_LOAD_ROM_LO;
         ST_LOAD_ROM_LO:   if (ld_fire) state_nx = ST_LOAD_ROM_HI;
         ST_LOAD_ROM_HI:   if (ld_fire) state_nx = rom_last ? ST_PRIME : ST_LOAD_ROM_LO;
         ST_PRIME:         state_nx = ST_RUN;
         ST_RUN:           if (cpu_idle) state_nx = ST_HALT;
         default:          state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ld_ptr     <= '0;
         lo_byte    <= '0;
         run_cycles <= '0;
      end else begin
         if (can_start && load_start) begin
            ld_ptr     <= '0;
            run_cycles <= '0;
         end
         if (ld_fire) begin
            case (state)
               ST_LOAD_RAM:    ld_ptr  <= ram_last ? '0 : ld_ptr + 1'b1;
               ST_LOAD_ROM_LO: lo_byte <= ld_data;
               ST_LOAD_ROM_HI: ld_ptr  <= rom_last ? '0 : ld_ptr + 1'b1;
               default:        ;
            endcase
         end
         if (state == ST_RUN && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
      end
   end

   // The loader owns the RAM write port in LOAD_RAM; the cpu owns it in PRIME/RUN.
   assign ram_we    = (state == ST_LOAD_RAM) ? ld_fire : (cpu_phase && cpu_sel && cpu_write);
   assign ram_waddr = (state == ST_LOAD_RAM) ? ld_ptr[AMSB:0] : cpu_addr;
   assign ram_wdata = (state == ST_LOAD_RAM) ? ld_data : cpu_wdata;
   assign rom_we    = (state == ST_LOAD_ROM_HI) && ld_fire;

   cpu_mem_sp #(.DW(DMSB + 1), .AW(AMSB + 1)) u_ram (
      .clk   (clk),
      .rstn  (rstn),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (cpu_phase && cpu_sel),
      .raddr (cpu_addr),
      .rdata (cpu_rdata)
   );

   cpu_mem_sp #(.DW(IMSB + 1), .AW(PMSB + 1)) u_rom (
      .clk   (clk),
      .rstn  (rstn),
      .we    (rom_we),
      .waddr (ld_ptr[PMSB:0]),
      .wdata ({ld_data, lo_byte}),
      .re    (cpu_phase),
      .raddr (cpu_pc),
      .rdata (cpu_inst)
   );

endmodule

// File: tb/tb_cpu_mem_host.sv
// tb/tb_cpu_mem_host.sv - directed self-checking bench for cpu_mem_host
module tb_cpu_mem_host;

   logic        clk = 1'b0;
   logic        rstn, load_start, ld_valid, ld_ready, busy, halted, cpu_setn;
   logic [7:0]  ld_data;
   logic [15:0] run_cycles;
   logic        cpu_idle, cpu_sel, cpu_write;
   logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata, cpu_pc;
   logic [15:0] cpu_inst;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  ram_img [256];
   logic [15:0] rom_img [256];

   typedef struct {
      logic [7:0]  pc;
      logic        sel, wr;
      logic [7:0]  addr, wdata;
      logic        idle, lds, ldv;
      logic [15:0] e_inst;
      logic [7:0]  e_rdata;
      logic        e_setn, e_halted;
      logic [15:0] e_cycles;
   } vec_t;

   vec_t tbl [12];

   cpu_mem_host dut (
      .clk        (clk),
      .rstn       (rstn),
      .load_start (load_start),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .busy       (busy),
      .halted     (halted),
      .run_cycles (run_cycles),
      .cpu_setn   (cpu_setn),
      .cpu_idle   (cpu_idle),
      .cpu_sel    (cpu_sel),
      .cpu_write  (cpu_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_pc     (cpu_pc),
      .cpu_inst   (cpu_inst)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] pc, input logic sel, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata,
                               input logic idle, input logic lds, input logic ldv,
                               input logic [15:0] e_inst, input logic [7:0] e_rdata,
                               input logic e_setn, input logic e_halted,
                               input logic [15:0] e_cycles);
      vec_t v;
      v.pc = pc; v.sel = sel; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.idle = idle; v.lds = lds; v.ldv = ldv;
      v.e_inst = e_inst; v.e_rdata = e_rdata; v.e_setn = e_setn;
      v.e_halted = e_halted; v.e_cycles = e_cycles;
      return v;
   endfunction

   function automatic logic [7:0] byte_at(input int idx);
      int k;
      if (idx < 256) return ram_img[idx];
      if (idx >= 768) return 8'h00;
      k = idx - 256;
      return k[0] ? rom_img[k >> 1][15:8] : rom_img[k >> 1][7:0];
   endfunction

   // Starts a load from IDLE/HALT and streams the images; gap inserts an idle cycle before every byte.
   task automatic load_program(input bit gap, output int accepted, output int cycles);
      bit offer;
      int idx;
      accepted = 0; cycles = 0; idx = 0;
      offer = !gap;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("load ld_ready", ld_ready, 1);
      check("load busy", busy, 1);
      while (ld_ready && cycles < 4000) begin
         ld_valid = offer;
         ld_data  = byte_at(idx);
         @(posedge clk);
         if (offer) begin
            accepted++;
            idx++;
         end
         cycles++;
         if (gap) offer = !offer;
         @(negedge clk);
      end
      ld_valid = 1'b0;
   endtask

   task automatic prime_and_check(input logic [15:0] first_inst);
      cpu_pc = 8'h00; cpu_sel = 1'b0; cpu_write = 1'b0; cpu_idle = 1'b0;
      check("prime setn", cpu_setn, 0);
      check("prime busy", busy, 1);
      @(negedge clk);
      check("run setn", cpu_setn, 1);
      check("run first inst", cpu_inst, first_inst);
      check("run cycles start", run_cycles, 0);
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         cpu_pc = tbl[i].pc; cpu_sel = tbl[i].sel; cpu_write = tbl[i].wr;
         cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata; cpu_idle = tbl[i].idle;
         load_start = tbl[i].lds; ld_valid = tbl[i].ldv; ld_data = 8'hEE;
         @(negedge clk);
         load_start = 1'b0; ld_valid = 1'b0;
         check($sformatf("v%0d inst", i), cpu_inst, tbl[i].e_inst);
         check($sformatf("v%0d rdata", i), cpu_rdata, tbl[i].e_rdata);
         check($sformatf("v%0d setn", i), cpu_setn, tbl[i].e_setn);
         check($sformatf("v%0d halted", i), halted, tbl[i].e_halted);
         check($sformatf("v%0d run_cycles", i), run_cycles, tbl[i].e_cycles);
         check($sformatf("v%0d ld_ready", i), ld_ready, 0);
      end
      cpu_sel = 1'b0; cpu_write = 1'b0; cpu_idle = 1'b0;
   endtask

   initial begin
      int acc, cyc;
      rstn = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
      cpu_idle = 1'b0; cpu_sel = 1'b0; cpu_write = 1'b0;
      cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_pc = 8'h00;

      // Program A: read 0x10, offered loader bytes in RUN, load_start ignored in RUN.
      tbl[0]  = mk(8'h01, 1, 0, 8'h10, 8'h00, 0, 0, 0, 16'h0000, 8'h10, 1, 0, 16'd1);
      tbl[1]  = mk(8'h02, 1, 0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 8'h00, 1, 0, 16'd2);
      tbl[2]  = mk(8'h03, 1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'd3);
      tbl[3]  = mk(8'h04, 1, 0, 8'h05, 8'h00, 0, 1, 0, 16'h0000, 8'h05, 1, 0, 16'd4);
      tbl[4]  = mk(8'h05, 0, 0, 8'h10, 8'h00, 0, 0, 0, 16'h0000, 8'h05, 1, 0, 16'd5);
      tbl[5]  = mk(8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0110, 8'h05, 0, 1, 16'd6);
      // Program B: write 0x77 to 0x42 with same-edge read returning the old byte.
      tbl[6]  = mk(8'h01, 1, 0, 8'h42, 8'h00, 0, 0, 0, 16'h0377, 8'h42, 1, 0, 16'd1);
      tbl[7]  = mk(8'h02, 1, 1, 8'h42, 8'h77, 0, 0, 0, 16'h0000, 8'h42, 1, 0, 16'd2);
      tbl[8]  = mk(8'h02, 1, 0, 8'h42, 8'h00, 0, 0, 0, 16'h0000, 8'h77, 1, 0, 16'd3);
      tbl[9]  = mk(8'h02, 1, 0, 8'h43, 8'h00, 0, 0, 0, 16'h0000, 8'h43, 1, 0, 16'd4);
      tbl[10] = mk(8'h01, 1, 0, 8'h05, 8'h00, 0, 0, 0, 16'h0377, 8'h05, 1, 0, 16'd5);
      tbl[11] = mk(8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0377, 8'h05, 0, 1, 16'd6);

      for (int i = 0; i < 256; i++) begin
         ram_img[i] = 8'(i);
         rom_img[i] = 16'h0000;
      end

      repeat (2) @(negedge clk);
      check("reset ld_ready", ld_ready, 0);
      check("reset busy", busy, 0);
      check("reset halted", halted, 0);
      check("reset setn", cpu_setn, 0);
      check("reset rdata", cpu_rdata, 0);
      check("reset inst", cpu_inst, 0);
      check("reset run_cycles", run_cycles, 0);
      rstn = 1'b1;
      @(negedge clk);

      rom_img[0] = 16'h0110;
      load_program(1'b1, acc, cyc);
      check("gap load accepted", acc, 768);
      check("gap load cycles", cyc, 1536);
      prime_and_check(16'h0110);
      run_vectors(0, 5);
      @(negedge clk);
      check("halt holds run_cycles", run_cycles, 6);
      check("halt holds halted", halted, 1);
      check("halt not busy", busy, 0);

      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("restart ld_ready", ld_ready, 1);
      check("restart run_cycles", run_cycles, 0);
      check("restart halted", halted, 0);
      for (int i = 0; i < 10; i++) begin
         ld_valid = 1'b1;
         ld_data  = 8'hA0 + 8'(i);
         @(negedge clk);
      end
      ld_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("midload rst ld_ready", ld_ready, 0);
      check("midload rst busy", busy, 0);
      check("midload rst inst", cpu_inst, 0);
      check("midload rst rdata", cpu_rdata, 0);
      check("midload rst halted", halted, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      rom_img[0] = 16'h0142;
      rom_img[1] = 16'h0377;
      load_program(1'b0, acc, cyc);
      check("load accepted", acc, 768);
      check("load cycles", cyc, 768);
      prime_and_check(16'h0142);
      run_vectors(6, 11);

      cpu_pc = 8'h00; cpu_sel = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h05; cpu_wdata = 8'h99;
      repeat (2) @(negedge clk);
      cpu_sel = 1'b0; cpu_write = 1'b0;
      check("halt gated inst", cpu_inst, 16'h0377);
      check("halt gated rdata", cpu_rdata, 8'h05);
      check("halt setn", cpu_setn, 0);

      #2 rstn = 1'b0;
      #1;
      check("final rst inst", cpu_inst, 0);
      check("final rst rdata", cpu_rdata, 0);
      check("final rst run_cycles", run_cycles, 0);
      check("final rst halted", halted, 0);
      @(negedge clk);
      rstn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
